// File: rtl/sram_ctrl_pkg.sv
// Shared state encodings, bus select codes and reset sense for the SRAM controller.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_ERR      = 3'd5
  } state_t;

  localparam logic [15:0] SRAM_SEL_BASE  = 16'h0001;
  localparam logic [15:0] SRAM_SEL_EXT   = 16'h0002;
  localparam logic [15:0] WB_SELECT_ZERO = 16'h0000;
  localparam logic [31:0] ZeroWord       = 32'h0000_0000;
  localparam logic        RstEnable      = 1'b0;

  // Counter reload value: the counter runs cycles-1 .. 0, one state clock per value.
  function automatic logic [3:0] wait_load(input int cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/sram_port.sv
// Pin driver for one asynchronous SRAM bank: turns registered phase flags into active-low strobes.
// Combinational only; the data bus is driven solely while a write phase is active, otherwise Z.
module sram_port #(
  parameter int AW = 20
) (
  input  logic          en,
  input  logic          rd,
  input  logic          wr_drive,
  input  logic          wr_pulse,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic [AW-1:0] ram_addr,
  inout  wire  [31:0]   ram_data,
  output logic          ce_n,
  output logic          oe_n,
  output logic          we_n
);

  assign ram_addr = addr;
  assign ce_n     = ~en;
  assign oe_n     = ~rd;
  assign we_n     = ~wr_pulse;
  assign ram_data = wr_drive ? wdata : 32'bz;
  assign rdata    = ram_data;

endmodule

// File: rtl/sram_ctrl.sv
// Level-ack bus slave sequencing async SRAM cycles on base/ext banks; ack low WAIT / WAIT+2 / 1 clocks
// for read / write / unmapped. ack low stalls the master; bus inputs are ignored until ack returns high.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int RAM_AW      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       bus_addr_i,
  input  logic [31:0]       bus_data_i,
  input  logic              bus_we_i,
  input  logic [15:0]       bus_select_i,
  output logic [31:0]       bus_data_o,
  output logic              bus_ack_o,
  output logic [RAM_AW-1:0] base_ram_addr,
  inout  wire  [31:0]       base_ram_data,
  output logic              base_ram_ce_n,
  output logic              base_ram_oe_n,
  output logic              base_ram_we_n,
  output logic [RAM_AW-1:0] ext_ram_addr,
  inout  wire  [31:0]       ext_ram_data,
  output logic              ext_ram_ce_n,
  output logic              ext_ram_oe_n,
  output logic              ext_ram_we_n
);

  localparam logic [3:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        cnt;
  logic [RAM_AW-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              ext_q;
  logic              en, rd, drive, pulse;
  logic [31:0]       base_rdata, ext_rdata;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{bus_addr_i[31:RAM_AW+2], bus_addr_i[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= ZeroWord;
      we_q       <= 1'b0;
      ext_q      <= 1'b0;
      en         <= 1'b0;
      rd         <= 1'b0;
      drive      <= 1'b0;
      pulse      <= 1'b0;
      bus_ack_o  <= 1'b1;
      bus_data_o <= ZeroWord;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus_select_i != WB_SELECT_ZERO) begin
            addr_q    <= bus_addr_i[RAM_AW+1:2];
            wdata_q   <= bus_data_i;
            we_q      <= bus_we_i;
            bus_ack_o <= 1'b0;
            if (bus_select_i == SRAM_SEL_BASE || bus_select_i == SRAM_SEL_EXT) begin
              ext_q <= (bus_select_i == SRAM_SEL_EXT);
              en    <= 1'b1;
              if (bus_we_i) begin
                drive <= 1'b1;
                state <= ST_WR_SETUP;
              end else begin
                rd    <= 1'b1;
                cnt   <= WAIT_LOAD;
                state <= ST_RD;
              end
            end else begin
              state <= ST_ERR;
            end
          end
        end
        ST_RD: begin
          if (cnt == 4'd0) begin
            bus_data_o <= ext_q ? ext_rdata : base_rdata;
            en         <= 1'b0;
            rd         <= 1'b0;
            bus_ack_o  <= 1'b1;
            state      <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WR_SETUP: begin
          pulse <= 1'b1;
          cnt   <= WAIT_LOAD;
          state <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (cnt == 4'd0) begin
            pulse <= 1'b0;
            state <= ST_WR_HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_WR_HOLD: begin
          en        <= 1'b0;
          drive     <= 1'b0;
          bus_ack_o <= 1'b1;
          state     <= ST_IDLE;
        end
        ST_ERR: begin
          // Unmapped reads return zero; unmapped writes leave the last read data alone.
          if (!we_q) bus_data_o <= ZeroWord;
          bus_ack_o <= 1'b1;
          state     <= ST_IDLE;
        end
        default: begin
          en        <= 1'b0;
          rd        <= 1'b0;
          drive     <= 1'b0;
          pulse     <= 1'b0;
          bus_ack_o <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  sram_port #(.AW(RAM_AW)) u_base (
    .en       (en    & ~ext_q),
    .rd       (rd    & ~ext_q),
    .wr_drive (drive & ~ext_q),
    .wr_pulse (pulse & ~ext_q),
    .addr     (addr_q),
    .wdata    (wdata_q),
    .rdata    (base_rdata),
    .ram_addr (base_ram_addr),
    .ram_data (base_ram_data),
    .ce_n     (base_ram_ce_n),
    .oe_n     (base_ram_oe_n),
    .we_n     (base_ram_we_n)
  );

  sram_port #(.AW(RAM_AW)) u_ext (
    .en       (en    & ext_q),
    .rd       (rd    & ext_q),
    .wr_drive (drive & ext_q),
    .wr_pulse (pulse & ext_q),
    .addr     (addr_q),
    .wdata    (wdata_q),
    .rdata    (ext_rdata),
    .ram_addr (ext_ram_addr),
    .ram_data (ext_ram_data),
    .ce_n     (ext_ram_ce_n),
    .oe_n     (ext_ram_oe_n),
    .we_n     (ext_ram_we_n)
  );

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: three instances (WAIT_CYCLES 1, 2, 15) each with two behavioural SRAM banks.
module tb_sram_ctrl;

  localparam int NI = 3;

  function automatic int wc_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 15;
  endfunction

  typedef struct {
    int          k;
    logic [15:0] sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] dat;
    int          exp_low;
    int          exp_nwe;
    int          exp_noe;
    logic [31:0] exp_dout;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] a_i [NI];
  logic [31:0] d_i [NI];
  logic        we_i [NI];
  logic [15:0] sel_i [NI];
  logic [31:0] d_o [NI];
  logic        ack [NI];
  logic [19:0] ba [NI];
  logic [19:0] ea [NI];
  logic        bce [NI], boe [NI], bwe [NI];
  logic        ece [NI], eoe [NI], ewe [NI];
  logic [31:0] bd_v [NI];
  logic [31:0] ed_v [NI];

  // Behavioural SRAM contents (device side) and the bench's own expectation of them.
  logic [31:0] bmem [NI][1024];
  logic [31:0] emem [NI][1024];
  logic [31:0] rbm [NI][1024];
  logic [31:0] rem [NI][1024];
  logic [31:0] last_d [NI];

  logic        clr, pl_vld, pl_ext;
  int          pl_k;
  logic [9:0]  pl_a;
  logic [31:0] pl_d;

  int n_tests;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wire [31:0] bd;
    wire [31:0] ed;
    sram_ctrl #(.WAIT_CYCLES(wc_of(g)), .RAM_AW(20)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus_addr_i    (a_i[g]),
      .bus_data_i    (d_i[g]),
      .bus_we_i      (we_i[g]),
      .bus_select_i  (sel_i[g]),
      .bus_data_o    (d_o[g]),
      .bus_ack_o     (ack[g]),
      .base_ram_addr (ba[g]),
      .base_ram_data (bd),
      .base_ram_ce_n (bce[g]),
      .base_ram_oe_n (boe[g]),
      .base_ram_we_n (bwe[g]),
      .ext_ram_addr  (ea[g]),
      .ext_ram_data  (ed),
      .ext_ram_ce_n  (ece[g]),
      .ext_ram_oe_n  (eoe[g]),
      .ext_ram_we_n  (ewe[g])
    );
    assign bd = (!bce[g] && !boe[g]) ? bmem[g][ba[g][9:0]] : 32'bz;
    assign ed = (!ece[g] && !eoe[g]) ? emem[g][ea[g][9:0]] : 32'bz;
    assign bd_v[g] = bd;
    assign ed_v[g] = ed;
  end

  always @(negedge clk) begin
    if (clr) begin
      for (int k = 0; k < NI; k++)
        for (int i = 0; i < 1024; i++) begin
          bmem[k][i] <= 32'h0;
          emem[k][i] <= 32'h0;
        end
    end else begin
      if (pl_vld) begin
        if (pl_ext) emem[pl_k][pl_a] <= pl_d;
        else        bmem[pl_k][pl_a] <= pl_d;
      end
      for (int k = 0; k < NI; k++) begin
        if (!bce[k] && !bwe[k]) bmem[k][ba[k][9:0]] <= bd_v[k];
        if (!ece[k] && !ewe[k]) emem[k][ea[k][9:0]] <= ed_v[k];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int k, input logic [15:0] sel, input logic we,
                              input logic [31:0] addr, input logic [31:0] dat, input int low,
                              input int nwe, input int noe, input logic [31:0] dout);
    vec_t v;
    v.k = k; v.sel = sel; v.we = we; v.addr = addr; v.dat = dat;
    v.exp_low = low; v.exp_nwe = nwe; v.exp_noe = noe; v.exp_dout = dout;
    return v;
  endfunction

  // Entered just after a rising edge with ack high; returns just after the edge where ack is high again.
  task automatic access(input vec_t v, output int low, output int nwe, output int noe,
                        output int nother, output int nbad, output logic first_we,
                        output logic last_we);
    logic mapped, ext_t, tce, toe, twe, oce, ooe, owe;
    logic [19:0] tad;
    int k;
    k = v.k;
    low = 0; nwe = 0; noe = 0; nother = 0; nbad = 0; first_we = 1'b1; last_we = 1'b1;
    mapped = (v.sel == 16'h0001) || (v.sel == 16'h0002);
    ext_t  = (v.sel == 16'h0002);
    a_i[k] = v.addr; d_i[k] = v.dat; we_i[k] = v.we; sel_i[k] = v.sel;
    @(posedge clk); #1;
    sel_i[k] = 16'h0;
    while (ack[k] == 1'b0 && low < 40) begin
      tce = ext_t ? ece[k] : bce[k];  toe = ext_t ? eoe[k] : boe[k];
      twe = ext_t ? ewe[k] : bwe[k];  tad = ext_t ? ea[k]  : ba[k];
      oce = ext_t ? bce[k] : ece[k];  ooe = ext_t ? boe[k] : eoe[k];
      owe = ext_t ? bwe[k] : ewe[k];
      if (mapped) begin
        if (low == 0) first_we = twe;
        last_we = twe;
        nwe += twe ? 0 : 1;
        noe += toe ? 0 : 1;
        if (!tce && tad != v.addr[21:2]) nbad++;
      end else begin
        nother += (tce ? 0 : 1) + (toe ? 0 : 1) + (twe ? 0 : 1);
      end
      nother += (oce ? 0 : 1) + (ooe ? 0 : 1) + (owe ? 0 : 1);
      low++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int low, nwe, noe, nother, nbad;
    logic fw, lw;
    access(v, low, nwe, noe, nother, nbad, fw, lw);
    check({tag, " ack-low cycles"}, low, v.exp_low);
    check({tag, " we_n low cycles"}, nwe, v.exp_nwe);
    check({tag, " oe_n low cycles"}, noe, v.exp_noe);
    check({tag, " stray strobes"}, nother, 0);
    check({tag, " bad sram addr"}, nbad, 0);
    check({tag, " setup we_n"}, {31'b0, fw}, 1);
    check({tag, " hold we_n"}, {31'b0, lw}, 1);
    check({tag, " bus_data_o"}, d_o[v.k], v.exp_dout);
  endtask

  vec_t tbl [17];

  initial begin
    n_tests = 0; n_fail = 0;
    clr = 1'b1; pl_vld = 1'b0; pl_ext = 1'b0; pl_k = 0; pl_a = '0; pl_d = '0;
    for (int k = 0; k < NI; k++) begin
      a_i[k] = '0; d_i[k] = '0; we_i[k] = 1'b0; sel_i[k] = '0; last_d[k] = '0;
      for (int i = 0; i < 1024; i++) begin rbm[k][i] = '0; rem[k][i] = '0; end
    end
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset ack[%0d]", k), {31'b0, ack[k]}, 1);
      check($sformatf("reset data_o[%0d]", k), d_o[k], 0);
      check($sformatf("reset strobes[%0d]", k),
            {26'b0, bce[k], boe[k], bwe[k], ece[k], eoe[k], ewe[k]}, 32'h3f);
      check($sformatf("reset addrs[%0d]", k), {ba[k], 12'b0} | {12'b0, ea[k]}, 0);
    end
    clr = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin
      pl_vld = 1'b1; pl_k = k; pl_ext = 1'b0; pl_a = 10'h010; pl_d = 32'hDEADBEEF;
      rbm[k][10'h010] = 32'hDEADBEEF;
      @(posedge clk); #1;
    end
    pl_vld = 1'b0;
    @(posedge clk); #1;

    tbl[0]  = mk(1, 16'h0001, 0, 32'h0000_0040, 32'h0,         2, 0, 2, 32'hDEADBEEF);
    tbl[1]  = mk(1, 16'h0002, 1, 32'h0000_0100, 32'h12345678,  4, 2, 0, 32'hDEADBEEF);
    tbl[2]  = mk(1, 16'h0002, 0, 32'h0000_0103, 32'h0,         2, 0, 2, 32'h12345678);
    tbl[3]  = mk(1, 16'h0004, 0, 32'h0000_0040, 32'h0,         1, 0, 0, 32'h0);
    tbl[4]  = mk(1, 16'h0001, 0, 32'h0000_0040, 32'h0,         2, 0, 2, 32'hDEADBEEF);
    tbl[5]  = mk(1, 16'h0003, 0, 32'h0000_0040, 32'h0,         1, 0, 0, 32'h0);
    tbl[6]  = mk(1, 16'h0001, 0, 32'h0000_0040, 32'h0,         2, 0, 2, 32'hDEADBEEF);
    tbl[7]  = mk(1, 16'h8000, 1, 32'h0000_0040, 32'hFFFFFFFF,  1, 0, 0, 32'hDEADBEEF);
    tbl[8]  = mk(1, 16'h0001, 0, 32'h0000_0040, 32'h0,         2, 0, 2, 32'hDEADBEEF);
    tbl[9]  = mk(0, 16'h0001, 0, 32'h0000_0040, 32'h0,         1, 0, 1, 32'hDEADBEEF);
    tbl[10] = mk(0, 16'h0001, 1, 32'h0000_0044, 32'hCAFEF00D,  3, 1, 0, 32'hDEADBEEF);
    tbl[11] = mk(0, 16'h0001, 0, 32'h0000_0044, 32'h0,         1, 0, 1, 32'hCAFEF00D);
    tbl[12] = mk(2, 16'h0001, 0, 32'h0000_0040, 32'h0,        15, 0, 15, 32'hDEADBEEF);
    tbl[13] = mk(2, 16'h0002, 1, 32'h0000_0008, 32'h0BADC0DE, 17, 15, 0, 32'hDEADBEEF);
    tbl[14] = mk(2, 16'h0002, 0, 32'h0000_0008, 32'h0,        15, 0, 15, 32'h0BADC0DE);
    tbl[15] = mk(2, 16'h0003, 1, 32'h0000_0008, 32'h0,         1, 0, 0, 32'h0BADC0DE);
    tbl[16] = mk(2, 16'h0002, 0, 32'h0000_0008, 32'h0,        15, 0, 15, 32'h0BADC0DE);
    for (int i = 0; i < 17; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    rem[1][10'h040] = 32'h12345678;
    rbm[0][10'h011] = 32'hCAFEF00D;
    rem[2][10'h002] = 32'h0BADC0DE;
    last_d[0] = 32'hCAFEF00D; last_d[1] = 32'hDEADBEEF; last_d[2] = 32'h0BADC0DE;

    // Write then read with select held: the read must be accepted on the edge ack rises.
    begin
      int n;
      a_i[1] = 32'h0000_0200; d_i[1] = 32'h600DF00D; we_i[1] = 1'b1; sel_i[1] = 16'h0001;
      @(posedge clk); #1;
      we_i[1] = 1'b0;
      n = 0;
      while (ack[1] == 1'b0 && n < 40) begin n++; @(posedge clk); #1; end
      check("b2b write ack-low cycles", n, 4);
      @(posedge clk); #1;
      check("b2b read accepted at ack edge", {31'b0, ack[1]}, 0);
      sel_i[1] = 16'h0;
      n = 0;
      while (ack[1] == 1'b0 && n < 40) begin n++; @(posedge clk); #1; end
      check("b2b read ack-low cycles", n, 2);
      check("b2b read data", d_o[1], 32'h600DF00D);
      rbm[1][10'h080] = 32'h600DF00D;
    end

    // Reset during the write pulse, before the SRAM model can latch anything.
    a_i[1] = 32'h0000_0040; d_i[1] = 32'h5555AAAA; we_i[1] = 1'b1; sel_i[1] = 16'h0001;
    @(posedge clk); #1;
    sel_i[1] = 16'h0;
    check("rst setup ce_n/we_n", {30'b0, bce[1], bwe[1]}, 32'h1);
    @(posedge clk); #1;
    check("rst pulse we_n", {31'b0, bwe[1]}, 0);
    #1 rst = 1'b0;
    #1;
    check("rst mid-write ack", {31'b0, ack[1]}, 1);
    check("rst mid-write data_o", d_o[1], 0);
    check("rst mid-write strobes",
          {26'b0, bce[1], boe[1], bwe[1], ece[1], eoe[1], ewe[1]}, 32'h3f);
    #1 rst = 1'b1;
    for (int k = 0; k < NI; k++) last_d[k] = 32'h0;
    @(posedge clk); #1;
    run_vec(mk(1, 16'h0001, 0, 32'h0000_0040, 32'h0, 2, 0, 2, 32'hDEADBEEF), "post-rst read");
    last_d[1] = 32'hDEADBEEF;

    // Randomised traffic against a transaction-level model of the two banks.
    for (int n = 0; n < 60; n++) begin
      int k, w, pick, word;
      logic [15:0] sel;
      logic we, mapped, ext;
      logic [31:0] addr, dat, dout;
      k = $urandom_range(0, NI - 1);
      w = wc_of(k);
      pick = $urandom_range(0, 5);
      case (pick)
        0, 4:    sel = 16'h0001;
        1, 5:    sel = 16'h0002;
        2:       sel = 16'h0003;
        default: sel = 16'(1 << $urandom_range(2, 15));
      endcase
      we = 1'($urandom_range(0, 1));
      word = $urandom_range(0, 1023);
      addr = ($urandom & 32'hFFC0_0003) | (32'(word) << 2);
      dat = $urandom;
      mapped = (sel == 16'h0001) || (sel == 16'h0002);
      ext = (sel == 16'h0002);
      if (!mapped) begin
        if (!we) last_d[k] = 32'h0;
      end else if (we) begin
        if (ext) rem[k][word] = dat; else rbm[k][word] = dat;
      end else begin
        last_d[k] = ext ? rem[k][word] : rbm[k][word];
      end
      dout = last_d[k];
      run_vec(mk(k, sel, we, addr, dat,
                 !mapped ? 1 : (we ? w + 2 : w),
                 (mapped && we) ? w : 0,
                 (mapped && !we) ? w : 0, dout),
              $sformatf("rnd%0d k%0d sel%04h we%0d", n, k, sel, we));
    end

    begin
      int ack_low [NI];
      int strobe_low [NI];
      for (int k = 0; k < NI; k++) begin ack_low[k] = 0; strobe_low[k] = 0; end
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) begin
          if (!ack[k]) ack_low[k]++;
          if (!(bce[k] & boe[k] & bwe[k] & ece[k] & eoe[k] & ewe[k])) strobe_low[k]++;
        end
      end
      for (int k = 0; k < NI; k++) begin
        check($sformatf("idle ack-low[%0d]", k), ack_low[k], 0);
        check($sformatf("idle strobes[%0d]", k), strobe_low[k], 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
